// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock/tick divider.
// Half-period defaults are terminal counts at a 100 MHz board clock.
package clk_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam logic [23:0] DEFAULT_HALF_5HZ  = 24'h989680;
  localparam logic [23:0] DEFAULT_HALF_50HZ = 24'h0F4240;

  // Output level at a terminal count without a mode change.
  function automatic logic term_level(input logic mode, input logic cur);
    return (mode == MODE_TOGGLE) ? ~cur : 1'b1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active count/half/mode plus a shadow register set
// so that divisor and mode changes only take effect on a period boundary.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W        = 24,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_5HZ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_mode_in,
  output logic             o_clkout,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half;
  logic             r_mode;
  logic [CNT_W-1:0] r_sh_half;
  logic             r_sh_mode;
  logic             r_pend;
  logic             r_clkout;
  logic             r_tick;

  logic w_at_half;
  logic w_term;

  assign w_at_half = (r_cnt == r_half);
  assign w_term    = i_en && w_at_half;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_half    <= DEFAULT_HALF;
      r_mode    <= MODE_TOGGLE;
      r_sh_half <= DEFAULT_HALF;
      r_sh_mode <= MODE_TOGGLE;
      r_pend    <= 1'b0;
      r_clkout  <= 1'b0;
      r_tick    <= 1'b0;
    end else if (i_sync) begin
      r_cnt    <= '0;
      r_clkout <= 1'b0;
      r_tick   <= 1'b0;
      r_pend   <= 1'b0;
      // A write in the same cycle bypasses the shadow and lands directly.
      if (i_wr) begin
        r_half    <= i_val;
        r_mode    <= i_mode_in;
        r_sh_half <= i_val;
        r_sh_mode <= i_mode_in;
      end else if (r_pend) begin
        r_half <= r_sh_half;
        r_mode <= r_sh_mode;
      end
    end else begin
      if (w_term) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
        if (r_pend && (r_sh_mode != r_mode)) begin
          r_clkout <= 1'b0;
        end else begin
          r_clkout <= term_level(r_mode, r_clkout);
        end
        if (r_pend) begin
          r_half <= r_sh_half;
          r_mode <= r_sh_mode;
        end
      end else if (i_en) begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
        if (r_mode == MODE_PULSE) begin
          r_clkout <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
        if (r_pend) begin
          r_half   <= r_sh_half;
          r_mode   <= r_sh_mode;
          r_cnt    <= '0;
          r_clkout <= 1'b0;
        end else if (r_mode == MODE_PULSE) begin
          r_clkout <= 1'b0;
        end
      end

      // The shadow is consumed by this cycle's terminal/disable before a fresh write refills it.
      if (i_wr) begin
        r_sh_half <= i_val;
        r_sh_mode <= i_mode_in;
        r_pend    <= 1'b1;
      end else if (!i_en || w_at_half) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_clkout = r_clkout;
  assign o_tick   = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator: decodes the load strobe
// onto one channel and runs NUM_CH independent dividers with a common SYNC.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned      NUM_CH       = 2,
  parameter int unsigned      CNT_W        = 24,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_5HZ),
  localparam int unsigned     SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] EN,
  input  logic              SYNC,
  input  logic              LOAD,
  input  logic [SEL_W-1:0]  LOAD_SEL,
  input  logic [CNT_W-1:0]  LOAD_VAL,
  input  logic              LOAD_MODE,
  output logic [NUM_CH-1:0] CLKOUT,
  output logic [NUM_CH-1:0] TICK
);

  logic [NUM_CH-1:0] w_wr;

  // Selects with no matching channel produce no strobe at all.
  always_comb begin
    w_wr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (LOAD && (32'(LOAD_SEL) == i)) begin
        w_wr[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_en      (EN[g]),
      .i_sync    (SYNC),
      .i_wr      (w_wr[g]),
      .i_val     (LOAD_VAL),
      .i_mode_in (LOAD_MODE),
      .o_clkout  (CLKOUT[g]),
      .o_tick    (TICK[g])
    );
  end

endmodule
